program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Boot-time loader for the CPU's memory port B. Receives a byte stream (valid/ready), assembles
//  big-endian 16-bit words, writes them to sequential addresses through the CPU's external port B
//  (memData/addr/writeEnable), verifies an XOR checksum, then releases the CPU from hold.
//  Sits directly upstream of the general CPU top level: drives its port-B inputs and gates its reset.
// PARAMETERS
//  WIDTH       16      data word width; the frame format fixes it at 16
//  ADDR_WIDTH  16      port-B address width
//  START_ADDR  0       address of the first loaded word
//  MAX_WORDS   1024    largest accepted word count; a larger count is a frame error
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous, active-high reset
//  start        in   1           1-cycle pulse; begins a load (honoured only in IDLE, DONE, ERR)
//  byteIn       in   8           stream byte
//  byteValid    in   1           byteIn is valid
//  byteReady    out  1           loader accepts byteIn this cycle
//  memData      out  WIDTH       word to write; drives CPU port-B write data
//  addr         out  ADDR_WIDTH  write address; drives CPU port-B address
//  writeEnable  out  1           1-cycle write strobe to CPU port B
//  cpuHold      out  1           1 = hold CPU in reset; top level inverts it into the CPU's active-low reset
//  wordCount    out  16          words written so far in the current load
//  done         out  1           load completed and checksum matched
//  error        out  1           frame error: count > MAX_WORDS, or checksum mismatch
// BEHAVIOUR
//  Reset values: state=IDLE; byteReady=0, writeEnable=0, memData=0, addr=0, wordCount=0,
//  done=0, error=0, cpuHold=1.
//  Byte transfer occurs only on a rising edge with byteValid & byteReady.
//  byteReady=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK.
//  Frame format: LEN_HI, LEN_LO (N, big-endian), then N x {DATA_HI, DATA_LO}, then CHK.
//  CHK = XOR of all 2N data bytes; the length bytes are excluded.
//  State machine:
//   IDLE    : start -> LEN_HI; clear wordCount, checksum, done, error; cpuHold=1.
//   LEN_HI  : byte -> N[15:8]; go to LEN_LO.
//   LEN_LO  : byte -> N[7:0]. If N > MAX_WORDS -> ERR. Else if N == 0 -> CHECK. Else -> DATA_HI.
//   DATA_HI : byte -> word[15:8]; XOR into checksum; go to DATA_LO.
//   DATA_LO : byte -> word[7:0]; XOR into checksum; go to WRITE.
//   WRITE   : exactly one cycle. writeEnable=1, memData=word, addr=(START_ADDR+wordCount) mod 2^ADDR_WIDTH.
//             On exit, wordCount++. If new wordCount == N -> CHECK, else -> DATA_HI.
//             byteReady=0 in this state.
//   CHECK   : byte == checksum -> DONE, else -> ERR.
//   DONE    : done=1, cpuHold=0; hold until start (start -> LEN_HI, cpuHold=1 the next cycle).
//   ERR     : error=1, cpuHold=1; start -> LEN_HI, clearing error.
//  memData and addr hold their last values outside WRITE; they are valid only while writeEnable=1.
//  Latency: a write strobe occurs 1 cycle after the DATA_LO handshake.
//  Minimum time per word is 3 cycles (DATA_HI, DATA_LO, WRITE).
//  A start pulse in any busy state (LEN_HI..CHECK) is ignored.
//  A byteValid level during a state with byteReady=0 is not consumed; the byte is held by the source.
//  Address wrap-around past 2^ADDR_WIDTH-1 is silent; there is no error.
//  Reset asserted mid-load: immediate return to IDLE with the reset values above.
//  Partially written memory is not cleaned up.
// TESTING
//  1. start; bytes 00 02 12 34 AB CD, CHK=12^34^AB^CD=40 -> writes (0,1234),(1,ABCD);
//     done=1, cpuHold 1->0, wordCount=2.
//  2. Same frame with CHK=41 -> both writes occur; error=1, done=0, cpuHold stays 1.
//  3. Count 0x0401 with MAX_WORDS=1024 -> ERR right after LEN_LO; no writeEnable pulse ever.
//  4. N=0 then CHK=00 -> DONE with no writes; N=0 then CHK=01 -> ERR.
//  5. byteValid toggled randomly, plus a start pulse injected mid-frame -> identical writes to test 1;
//     the start is ignored; writeEnable is never high on two consecutive cycles.
//  6. reset asserted between DATA_HI and DATA_LO of word 1 -> outputs go to reset values immediately;
//     a new start followed by the test-1 frame then succeeds.
//  Also cover START_ADDR=16'hFFFF with N=2 -> writes go to FFFF then 0000.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader for CPU memory port B. Accepts a byte stream over a valid/ready
//   handshake, assembles big-endian 16-bit words, writes them to sequential port-B
//   addresses, verifies an XOR checksum over the data bytes, then releases the CPU.
//
//   Frame: LEN_HI, LEN_LO (N), N x {DATA_HI, DATA_LO}, CHK (XOR of the 2N data bytes).
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        1-cycle pulse; begins a load when idle, done or in error
//   byteIn       stream byte
//   byteValid    byteIn is valid
//   byteReady    loader accepts byteIn this cycle
//   memData      port-B write data (valid only while writeEnable=1)
//   addr         port-B write address (valid only while writeEnable=1)
//   writeEnable  1-cycle port-B write strobe
//   cpuHold      1 = hold CPU in reset
//   wordCount    words written so far in the current load
//   done         load completed with matching checksum
//   error        length above MAX_WORDS, or checksum mismatch
module program_loader #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            byteIn,
   input  logic                  byteValid,
   output logic                  byteReady,
   output logic [WIDTH-1:0]      memData,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  writeEnable,
   output logic                  cpuHold,
   output logic [15:0]           wordCount,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [3:0] {
      StIdle,
      StLenHi,
      StLenLo,
      StDataHi,
      StDataLo,
      StWrite,
      StCheck,
      StDone,
      StErr
   } state_t;

   state_t          state;
   logic [7:0]      len_hi;
   logic [15:0]     word_len;
   logic [7:0]      data_hi;
   logic [7:0]      checksum;

   logic                  take;
   logic [15:0]           len_next;
   logic [15:0]           count_inc;
   logic [ADDR_WIDTH-1:0] next_addr;

   always_comb begin
      take      = byteValid & byteReady;
      len_next  = {len_hi, byteIn};
      count_inc = wordCount + 16'd1;
      // Address arithmetic wraps silently at 2^ADDR_WIDTH.
      next_addr = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(wordCount);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         byteReady   <= 1'b0;
         writeEnable <= 1'b0;
         memData     <= '0;
         addr        <= '0;
         wordCount   <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
         cpuHold     <= 1'b1;
         len_hi      <= '0;
         word_len    <= '0;
         data_hi     <= '0;
         checksum    <= '0;
      end else begin
         writeEnable <= 1'b0;
         unique case (state)
            // Start is only honoured from the three resting states.
            StIdle, StDone, StErr: begin
               if (start) begin
                  state     <= StLenHi;
                  byteReady <= 1'b1;
                  wordCount <= '0;
                  checksum  <= '0;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  cpuHold   <= 1'b1;
               end
            end
            StLenHi: begin
               if (take) begin
                  len_hi <= byteIn;
                  state  <= StLenLo;
               end
            end
            StLenLo: begin
               if (take) begin
                  word_len <= len_next;
                  if (32'(len_next) > MAX_WORDS) begin
                     state     <= StErr;
                     byteReady <= 1'b0;
                     error     <= 1'b1;
                  end else if (len_next == 16'd0) begin
                     state <= StCheck;
                  end else begin
                     state <= StDataHi;
                  end
               end
            end
            StDataHi: begin
               if (take) begin
                  data_hi  <= byteIn;
                  checksum <= checksum ^ byteIn;
                  state    <= StDataLo;
               end
            end
            StDataLo: begin
               if (take) begin
                  // Strobe is registered here so it appears the cycle after the handshake.
                  memData     <= WIDTH'({data_hi, byteIn});
                  addr        <= next_addr;
                  writeEnable <= 1'b1;
                  checksum    <= checksum ^ byteIn;
                  byteReady   <= 1'b0;
                  state       <= StWrite;
               end
            end
            StWrite: begin
               wordCount <= count_inc;
               byteReady <= 1'b1;
               state     <= (count_inc == word_len) ? StCheck : StDataHi;
            end
            StCheck: begin
               if (take) begin
                  byteReady <= 1'b0;
                  if (byteIn == checksum) begin
                     state   <= StDone;
                     done    <= 1'b1;
                     cpuHold <= 1'b0;
                  end else begin
                     state <= StErr;
                     error <= 1'b1;
                  end
               end
            end
            default: begin
               state     <= StIdle;
               byteReady <= 1'b0;
               cpuHold   <= 1'b1;
            end
         endcase
      end
   end

endmodule
